// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
//
// Purpose:
//   Bundles the request/response signals between the core's M-extension
//   datapath and the multi-cycle divider. The core side uses the master
//   modport, the divider uses the slave modport.
//
// Signals:
//   enable_div       master->slave  start request, honoured only while idle
//   operation[1:0]   master->slave  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   oper_a           master->slave  dividend
//   oper_b           master->slave  divisor
//   div_o            slave->master  quotient or remainder, held between ops
//   divided_by_zero  slave->master  current result came from a zero divisor
//   busy             slave->master  divider is working or presenting a result
//   div_finish       slave->master  one-cycle completion pulse
// ----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
);

    logic             enable_div;
    logic [1:0]       operation;
    logic [WIDTH-1:0] oper_a;
    logic [WIDTH-1:0] oper_b;
    logic [WIDTH-1:0] div_o;
    logic             divided_by_zero;
    logic             busy;
    logic             div_finish;

    modport master (
        output enable_div,
        output operation,
        output oper_a,
        output oper_b,
        input  div_o,
        input  divided_by_zero,
        input  busy,
        input  div_finish
    );

    modport slave (
        input  enable_div,
        input  operation,
        input  oper_a,
        input  oper_b,
        output div_o,
        output divided_by_zero,
        output busy,
        output div_finish
    );

endinterface

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//
// Purpose:
//   Radix-2 restoring divider for the RV32IM DIV/DIVU/REM/REMU instructions.
//   Signed operands are reduced to magnitudes up front, WIDTH shift/subtract
//   iterations produce an unsigned quotient and remainder, and the signs are
//   re-applied on the final iteration edge. Divide-by-zero and the signed
//   overflow case (most-negative / -1) bypass the iterations and complete
//   immediately with the RISC-V defined results.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; aborts any operation in flight
//   bus   seq_divider_if.slave (start request, operands, result, handshake)
//
// Parameters:
//   WIDTH operand/result width (>= 4)
//   CNT_W iteration counter width, derived from WIDTH
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] div_o_q, div_o_d;
    logic             dbz_q, dbz_d;

    // Operand preparation, evaluated on the raw bus inputs for the accepting edge.
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             b_zero;
    logic             sign_overflow;
    logic             start;

    // One restoring iteration on the registered state.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;

    // Negating the most-negative value yields the same bit pattern, which read
    // as unsigned is exactly its magnitude, so no extra bit is needed.
    always_comb begin
        op_signed     = ~bus.operation[0];
        a_neg         = op_signed & bus.oper_a[WIDTH-1];
        b_neg         = op_signed & bus.oper_b[WIDTH-1];
        abs_a         = a_neg ? -bus.oper_a : bus.oper_a;
        abs_b         = b_neg ? -bus.oper_b : bus.oper_b;
        b_zero        = (bus.oper_b == '0);
        sign_overflow = op_signed && (bus.oper_a == MOST_NEG) && (bus.oper_b == ALL_ONES);
        start         = (state_q == IDLE) && bus.enable_div;
    end

    // The dividend is shifted out of the top of quo_q into the partial
    // remainder while quotient bits enter at the bottom. A borrow in the
    // extra top bit of the trial difference means the divisor did not fit.
    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};
        trial_ok  = ~trial[WIDTH];
        rem_next  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], trial_ok};
        last_iter = (cnt_q == CNT_W'(1));
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div_o_q   <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div_o_q   <= div_o_d;
            dbz_q     <= dbz_d;
        end
    end

    // Next-state logic. The special cases skip CALC entirely; DONE always
    // lasts one cycle so a request held high cannot retrigger immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.enable_div) begin
                    state_d = (b_zero || sign_overflow) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. Only the bit that selects quotient vs remainder
    // is kept from the opcode; signedness is already folded into the
    // magnitudes and the two sign flags.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div_o_d   = div_o_q;
        dbz_d     = dbz_q;

        if (start) begin
            is_rem_d = bus.operation[1];
            if (b_zero) begin
                div_o_d = bus.operation[1] ? bus.oper_a : ALL_ONES;
                dbz_d   = 1'b1;
            end else if (sign_overflow) begin
                div_o_d = bus.operation[1] ? '0 : bus.oper_a;
                dbz_d   = 1'b0;
            end else begin
                cnt_d     = CNT_W'(WIDTH);
                rem_d     = '0;
                quo_d     = abs_a;
                dvs_d     = abs_b;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                dbz_d     = 1'b0;
            end
        end else if (state_q == CALC) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q - CNT_W'(1);
            // Sign correction uses this edge's iteration result so the
            // answer is ready in the same edge the counter runs out.
            if (last_iter) begin
                if (is_rem_q) begin
                    div_o_d = neg_rem_q ? -rem_next : rem_next;
                end else begin
                    div_o_d = neg_quo_q ? -quo_next : quo_next;
                end
            end
        end
    end

    // Outputs are either registered values or decoded directly from state.
    always_comb begin
        bus.busy            = (state_q != IDLE);
        bus.div_finish      = (state_q == DONE);
        bus.div_o           = div_o_q;
        bus.divided_by_zero = dbz_q;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle, parametrised-width radix-2 restoring divider for the RV32IM M-extension datapath.
- Executes DIV, DIVU, REM and REMU, including the RISC-V divide-by-zero and signed-overflow results.
- Uses a start/busy/finish handshake so the core pipeline can stall on it.
- Replaces the earlier single-cycle combinational divider.

Parameters:
- WIDTH, 32, operand and result width in bits (must be ≥ 4).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- enable_div  input  1  start request, sampled in IDLE only
- operation  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- oper_a  input  WIDTH  dividend
- oper_b  input  WIDTH  divisor
- div_o  output  WIDTH  quotient or remainder; held until the next accepted start
- divided_by_zero  output  1  set when the current result came from oper_b==0; held with div_o
- busy  output  1  high in CALC and DONE
- div_finish  output  1  one-cycle completion pulse (high in DONE)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; div_o=0; divided_by_zero=0; busy=0; div_finish=0; counter, remainder and quotient registers cleared.
- rst wins over every other event, including reset during CALC: the operation is aborted and no div_finish is produced.
- States: IDLE, CALC, DONE.
- IDLE, enable_div=1 at edge E0: latch operation, oper_a and oper_b, then branch on the first matching case:
  - oper_b==0: go to DONE; divided_by_zero=1; div_o = all-ones for DIV/DIVU, oper_a for REM/REMU.
  - Signed op with oper_a = 1<<(WIDTH-1) and oper_b = all-ones: go to DONE; divided_by_zero=0; div_o = oper_a for DIV, 0 for REM.
  - Otherwise: go to CALC; counter=WIDTH; divided_by_zero=0.
- Operand conversion at E0: for signed ops, take absolute values of both operands and record sign_q = a_sign XOR b_sign and sign_r = a_sign. For unsigned ops, use raw operands with both signs 0.
- CALC, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem(WIDTH+1 bits) − divisor.
  - If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Decrement the counter.
- CALC exit: on the edge where the counter reaches 0, load div_o with the final value and move to DONE.
  - DIV/DIVU: quotient, negated if sign_q.
  - REM/REMU: remainder, negated if sign_r.
  - Final correction happens in that same edge.
- DONE: div_finish=1 for exactly one cycle. Next edge returns to IDLE unconditionally; enable_div is ignored in DONE.
- Latency:
  - Normal operation: div_finish is high in the cycle after E_WIDTH, i.e. WIDTH cycles after the accepting edge.
  - Special cases: div_finish is high in the cycle immediately after E0.
- Back-to-back: the earliest next acceptance is the edge that leaves DONE+1, i.e. one IDLE cycle between operations.
- enable_div while busy=1 is ignored: no queuing, latched operands unchanged.
- oper_a, oper_b and operation may change freely after acceptance without affecting the result.
- div_o and divided_by_zero change only at completion or reset, never mid-CALC.
- All arithmetic is modulo 2^WIDTH.
  - Quotient rounds toward zero.
  - Remainder sign follows the dividend.
  - Invariant: a = q·b + r.

Test Plan:
- WIDTH=32, DIV 7/3 → div_o=2, div_finish 32 cycles after accept; REM 7/3 → 1; DIV −7/3 → 0xFFFFFFFE; REM −7/3 → 0xFFFFFFFF; DIV 7/−3 → 0xFFFFFFFE, REM → 1; DIV −7/−3 → 2, REM → 0xFFFFFFFF.
- DIV −7/0 → div_o=0xFFFFFFFF, divided_by_zero=1, div_finish 1 cycle after accept; REM −7/0 → 0xFFFFFFF9; DIVU 5/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, divided_by_zero=0, 1-cycle finish; REM same operands → 0.
- DIVU 3025/12 → 252, REMU → 1; DIVU 0xA9D64154/0xD98825ED → 0, REMU → 0xA9D64154; DIV of same operands → 2, REM → 0xF6C5F57A.
- Handshake: enable_div held high and operands changed during CALC → result of the first operands only, single div_finish pulse, busy high for exactly WIDTH+1 cycles; next accept only after one IDLE cycle.
- Reset: assert rst during CALC iteration 10 → next cycle busy=0, div_o=0, divided_by_zero=0, no div_finish. Separately, WIDTH=8 instance: DIVU 200/7 → 28, REMU → 4, finish 8 cycles after accept.
